// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC interval datapath.
// Provides the default widths and scales used by the interval block and its
// coarse counter, the FSM state encoding, and the bit positions inside
// result_flags.
package tdc_pkg;

  localparam int TDC_FINE_W         = 6;
  localparam int TDC_FINE_PER_CYCLE = 64;
  localparam int TDC_COARSE_W       = 16;
  localparam int TDC_RESULT_W       = 24;
  localparam int TDC_TIMEOUT_CYCLES = 50000;

  localparam int FLAG_TIMEOUT = 0;
  localparam int FLAG_NEG     = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STOP = 2'd1,
    CALC      = 2'd2,
    HOLD      = 2'd3
  } tdc_state_e;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Free-running coarse timestamp counter.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset, clears the count
//   count_o - current coarse count, wraps modulo 2**COARSE_W
module tdc_coarse_counter
  import tdc_pkg::*;
#(
  parameter int COARSE_W = TDC_COARSE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [COARSE_W-1:0] count_o
);

  logic [COARSE_W-1:0] count_q;

  // The counter advances on every clock with no enable; natural overflow of
  // the register gives the modulo-2**COARSE_W wrap the interval math relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + COARSE_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tdc_interval.sv
// Start/stop interval measurement behind the carry-chain delay line.
// A start event stamps the coarse counter and its fine tap count, the next stop
// event does the same, and one cycle later the interval in fine-tap units is
// presented on a valid/ready port until the consumer takes it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start_valid/_fine   - start channel strobe and fine count
//   stop_valid/_fine    - stop channel strobe and fine count
//   result_valid/_ready - result handshake toward the report stage
//   result              - interval in fine units, saturated at all-ones
//   result_flags        - [0] timeout, [1] negative interval (result forced 0)
//   drop_count          - saturating count of start events ignored while busy
//   busy                - high whenever the FSM is not in IDLE
module tdc_interval
  import tdc_pkg::*;
#(
  parameter int FINE_W         = TDC_FINE_W,
  parameter int FINE_PER_CYCLE = TDC_FINE_PER_CYCLE,
  parameter int COARSE_W       = TDC_COARSE_W,
  parameter int RESULT_W       = TDC_RESULT_W,
  parameter int TIMEOUT_CYCLES = TDC_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  input  logic [FINE_W-1:0]   start_fine,
  input  logic                stop_valid,
  input  logic [FINE_W-1:0]   stop_fine,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [RESULT_W-1:0] result,
  output logic [1:0]          result_flags,
  output logic [7:0]          drop_count,
  output logic                busy
);

  localparam int CALC_W = RESULT_W + 2;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  tdc_state_e state_q, state_d;

  logic [COARSE_W-1:0] coarseNow;
  logic [COARSE_W-1:0] coarseStart_q, coarseStart_d;
  logic [COARSE_W-1:0] coarseStop_q, coarseStop_d;
  logic [FINE_W-1:0]   startFine_q, startFine_d;
  logic [FINE_W-1:0]   stopFine_q, stopFine_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [1:0]          flags_q, flags_d;
  logic [7:0]          dropCnt_q, dropCnt_d;

  logic [COARSE_W-1:0] coarseDelta;
  logic [CALC_W-1:0]   calcRaw;

  tdc_coarse_counter #(
    .COARSE_W (COARSE_W)
  ) u_coarse (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_o (coarseNow)
  );

  // Interval arithmetic on the latched stamps. The coarse difference wraps
  // naturally in COARSE_W bits. Start fine is added and stop fine subtracted
  // because a larger tap count means the edge arrived earlier in the period.
  // The sum is two bits wider than the result so that its top bit reads as a
  // sign and the next bit catches overflow past the result width.
  assign coarseDelta = coarseStop_q - coarseStart_q;
  assign calcRaw     = CALC_W'(coarseDelta) * CALC_W'(FINE_PER_CYCLE)
                     + CALC_W'(startFine_q) - CALC_W'(stopFine_q);

  // Next-state logic for the FSM and all of its datapath registers.
  // Every register holds by default. Any start pulse that arrives outside IDLE
  // is counted as a drop, and the count sticks at 255.
  always_comb begin
    state_d       = state_q;
    coarseStart_d = coarseStart_q;
    coarseStop_d  = coarseStop_q;
    startFine_d   = startFine_q;
    stopFine_d    = stopFine_q;
    toCnt_d       = toCnt_q;
    result_d      = result_q;
    flags_d       = flags_q;
    dropCnt_d     = dropCnt_q;

    if (start_valid && (state_q != IDLE) && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          coarseStart_d = coarseNow;
          startFine_d   = start_fine;
          toCnt_d       = '0;
          state_d       = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        if (stop_valid) begin
          coarseStop_d = coarseNow;
          stopFine_d   = stop_fine;
          state_d      = CALC;
        end else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          result_d              = '0;
          flags_d               = '0;
          flags_d[FLAG_TIMEOUT] = 1'b1;
          state_d               = HOLD;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      CALC: begin
        flags_d = '0;
        state_d = HOLD;
        if (calcRaw[CALC_W-1]) begin
          result_d          = '0;
          flags_d[FLAG_NEG] = 1'b1;
        end else if (|calcRaw[CALC_W-2:RESULT_W]) begin
          result_d = '1;
        end else begin
          result_d = calcRaw[RESULT_W-1:0];
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops the FSM back to IDLE, which also
  // discards any result that was waiting for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      coarseStart_q <= '0;
      coarseStop_q  <= '0;
      startFine_q   <= '0;
      stopFine_q    <= '0;
      toCnt_q       <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      dropCnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      coarseStart_q <= coarseStart_d;
      coarseStop_q  <= coarseStop_d;
      startFine_q   <= startFine_d;
      stopFine_q    <= stopFine_d;
      toCnt_q       <= toCnt_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      dropCnt_q     <= dropCnt_d;
    end
  end

  // The result is offered for exactly as long as the FSM sits in HOLD, so it
  // can only be withdrawn by a handshake or by reset.
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_flags = flags_q;
  assign drop_count   = dropCnt_q;

endmodule

// File: tb/tb_tdc_interval.sv
// Self-checking bench for tdc_interval.
// The DUT runs with an 8-bit coarse counter, a 13-bit result and a 300-cycle
// timeout so that wrap, zero-delta negative, saturation and timeout are all
// reachable in a short run. Expected results come from an arithmetic model of
// the interval rules and are queued when the stop is driven. A separate
// monitor pops the queue on every handshake and also checks that a pending
// result stays put while the consumer stalls.
module tb_tdc_interval;

  localparam int FW  = 6;
  localparam int FPC = 64;
  localparam int CW  = 8;
  localparam int RW  = 13;
  localparam int TO  = 300;
  localparam int M   = 1 << CW;

  typedef struct {
    int res;
    int fl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_valid = 1'b0;
  logic [FW-1:0] start_fine = '0;
  logic          stop_valid = 1'b0;
  logic [FW-1:0] stop_fine = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [RW-1:0] result;
  logic [1:0]    result_flags;
  logic [7:0]    drop_count;
  logic          busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   tbCoarse = 0;
  int   expDrops = 0;
  int   readyMode = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tdc_interval #(
    .FINE_W         (FW),
    .FINE_PER_CYCLE (FPC),
    .COARSE_W       (CW),
    .RESULT_W       (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_fine   (start_fine),
    .stop_valid   (stop_valid),
    .stop_fine    (stop_fine),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_flags (result_flags),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  // Reference notion of "now" in coarse units: clocks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tbCoarse <= 0;
    else        tbCoarse <= (tbCoarse + 1) % M;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
    vectors++;
    if (act !== expVal) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expVal, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t refModel(input int sc, input int sf, input int ec, input int ef);
    exp_t e;
    int dc;
    int v;
    dc = ((ec - sc) % M + M) % M;
    v  = dc * FPC + sf - ef;
    if (v < 0) begin
      e.res = 0;
      e.fl  = 2;
    end else if (v > (1 << RW) - 1) begin
      e.res = (1 << RW) - 1;
      e.fl  = 0;
    end else begin
      e.res = v;
      e.fl  = 0;
    end
    return e;
  endfunction

  task automatic bumpDrop();
    if (expDrops < 255) expDrops++;
  endtask

  task automatic maybeDrop(input int pct);
    if (int'($urandom_range(99)) < pct) begin
      start_valid = 1'b1;
      start_fine  = FW'($urandom_range(63));
      bumpDrop();
    end
  endtask

  // One start/stop transaction: start this cycle, stop 'gap' cycles later,
  // optional drop pulses while busy, then the two-cycle latency check.
  task automatic applyStimulus(input int sFine, input int eFine, input int gap,
                               input int dropPct, input bit coStop, input bit push);
    int sc;
    int ec;
    start_valid = 1'b1;
    start_fine  = FW'(sFine);
    sc = tbCoarse;
    if (coStop) begin
      stop_valid = 1'b1;
      stop_fine  = FW'($urandom_range(63));
    end
    tick();
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    for (int i = 1; i < gap; i++) begin
      maybeDrop(dropPct);
      tick();
      start_valid = 1'b0;
    end
    stop_valid = 1'b1;
    stop_fine  = FW'(eFine);
    ec = tbCoarse;
    maybeDrop(dropPct);
    if (push) sb.push_back(refModel(sc, sFine, ec, eFine));
    tick();
    stop_valid  = 1'b0;
    start_valid = 1'b0;
    checkOutput("calc_valid_low", 32'(result_valid), 0);
    checkOutput("calc_busy", 32'(busy), 1);
    maybeDrop(dropPct);
    tick();
    start_valid = 1'b0;
    checkOutput("latency_valid", 32'(result_valid), 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 0);
    checkOutput("idle_after_hs", 32'(busy), 0);
  endtask

  task automatic waitCoarse(input int target);
    int n = 0;
    while (tbCoarse != target && n < 2 * M) begin
      tick();
      n++;
    end
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    start_valid = 1'b0;
    stop_valid  = 1'b0;
    sb.delete();
    expDrops = 0;
    #1;
    checkOutput("rst_valid", 32'(result_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_flags", 32'(result_flags), 0);
    checkOutput("rst_drops", 32'(drop_count), 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Consumer side: ready always high, random, or held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       result_ready = 1'b1;
        1:       result_ready = ($urandom_range(99) < 60);
        default: result_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks that a stalled
  // result is held unchanged until it is accepted.
  initial begin
    logic          held;
    logic [RW-1:0] heldRes;
    logic [1:0]    heldFl;
    exp_t          e;
    held = 1'b0;
    heldRes = '0;
    heldFl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", 32'(result_valid), 1);
          checkOutput("hold_result", 32'(result), 32'(heldRes));
          checkOutput("hold_flags", 32'(result_flags), 32'(heldFl));
        end
        if (result_valid && result_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_result: got %0d flags %0d expected none", result, result_flags);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_result", 32'(result), e.res);
            checkOutput("sb_flags", 32'(result_flags), e.fl);
          end
        end else if (result_valid) begin
          held = 1'b1;
          heldRes = result;
          heldFl = result_flags;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    doReset();

    $display("[TB] directed: basic interval");
    waitCoarse(100);
    applyStimulus(10, 40, 3, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] directed: start and stop together in IDLE");
    applyStimulus(0, 63, 1, 0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] directed: zero coarse delta, negative");
    applyStimulus(5, 9, M, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] directed: saturation");
    applyStimulus(0, 0, 150, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] directed: coarse wrap");
    waitCoarse(M - 6);
    applyStimulus(0, 0, 10, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] directed: stop on the last timeout cycle");
    applyStimulus(7, 3, TO, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] directed: timeout with stalled consumer");
    readyMode = 2;
    tick();
    tick();
    start_valid = 1'b1;
    start_fine  = FW'(17);
    tick();
    start_valid = 1'b0;
    repeat (TO - 1) tick();
    checkOutput("to_not_yet", 32'(result_valid), 0);
    checkOutput("to_busy", 32'(busy), 1);
    sb.push_back('{0, 1});
    tick();
    checkOutput("to_valid", 32'(result_valid), 1);
    checkOutput("to_result", 32'(result), 0);
    checkOutput("to_flags", 32'(result_flags), 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 8 || i == 15) begin
        start_valid = 1'b1;
        bumpDrop();
      end
      tick();
      start_valid = 1'b0;
    end
    checkOutput("hold_drops", 32'(drop_count), expDrops);
    readyMode = 0;
    waitDrain();

    $display("[TB] random transactions");
    readyMode = 1;
    for (int t = 0; t < 30; t++) begin
      int gap;
      if ($urandom_range(99) < 20) begin
        stop_valid = 1'b1;
        stop_fine  = FW'($urandom_range(63));
        tick();
        stop_valid = 1'b0;
      end
      gap = ($urandom_range(99) < 70) ? int'($urandom_range(20, 1)) : int'($urandom_range(TO, 1));
      applyStimulus(int'($urandom_range(63)), int'($urandom_range(63)), gap, 15,
                    ($urandom_range(99) < 10), 1'b1);
      waitDrain();
    end
    checkOutput("rand_drops", 32'(drop_count), expDrops);
    readyMode = 0;

    $display("[TB] directed: drop counter saturation");
    readyMode = 2;
    tick();
    tick();
    applyStimulus(3, 1, 5, 0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      start_valid = 1'b1;
      bumpDrop();
      tick();
    end
    start_valid = 1'b0;
    checkOutput("drop_sat", 32'(drop_count), expDrops);
    readyMode = 0;
    waitDrain();

    $display("[TB] directed: reset while waiting for stop");
    start_valid = 1'b1;
    start_fine  = FW'(12);
    tick();
    start_valid = 1'b0;
    repeat (5) tick();
    checkOutput("pre_rst_busy", 32'(busy), 1);
    doReset();
    repeat (10) tick();
    checkOutput("post_rst_idle", 32'(busy), 0);

    $display("[TB] directed: reset while holding a result");
    readyMode = 2;
    tick();
    tick();
    applyStimulus(9, 2, 4, 0, 1'b0, 1'b0);
    doReset();
    readyMode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("no_stale_valid", 32'(result_valid), 0);
    end
    applyStimulus(1, 2, 2, 0, 1'b0, 1'b1);
    waitDrain();

    checkOutput("sb_empty_end", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
